// File: rtl/stage_seq_fsm.sv
// stage_seq_fsm: parametrised N-stage sequence checker.
// Walks IDLE -> stage 0 .. stage N-1 -> IDLE under the en/step qualifiers.
// Illegal input combinations are trapped in ERROR. There is also a
// completion pulse and a saturating count of ERROR entries.
// Every output is registered, so an output follows its sampled inputs by one
// cycle and no combinational path runs from an input to an output.
// Optional build macro: DWELL_TIMEOUT_EN. When it is defined, a per-stage
// dwell watchdog forces ERROR after MAX_DWELL idle cycles spent in one stage.
module stage_seq_fsm #(
    parameter int NUM_STAGES = 2,
    parameter int IDX_W      = 4,
    parameter int ERR_CNT_W  = 8,
    parameter int MAX_DWELL  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  step,
    output logic [NUM_STAGES-1:0] stage_oh,
    output logic [IDX_W-1:0]      stage_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  timeout,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    // Control modes. The stage number is held separately in idx_reg, so
    // adding stages does not grow the mode encoding. Encoding 2'b11 is
    // unused and falls back to IDLE.
    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_RUN  = 2'd1;
    localparam logic [1:0] MODE_ERR  = 2'd2;

    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_STAGES - 1);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};

    logic [1:0]            mode_reg;
    logic [1:0]            mode_next;
    logic [IDX_W-1:0]      idx_reg;
    logic [IDX_W-1:0]      idx_next;
    logic                  done_next;
    logic                  timeout_next;

    logic [NUM_STAGES-1:0] stage_oh_reg;
    logic [NUM_STAGES-1:0] stage_oh_next;
    logic [IDX_W-1:0]      stage_idx_reg;
    logic [IDX_W-1:0]      stage_idx_next;
    logic                  busy_reg;
    logic                  busy_next;
    logic                  done_reg;
    logic                  err_reg;
    logic                  err_next;
    logic [ERR_CNT_W-1:0]  err_cnt_reg;
    logic [ERR_CNT_W-1:0]  err_cnt_next;

`ifdef DWELL_TIMEOUT_EN
    localparam int DWELL_W = $clog2(MAX_DWELL + 1);
    localparam logic [DWELL_W-1:0] DWELL_LIMIT = DWELL_W'(MAX_DWELL);

    logic [DWELL_W-1:0]    dwell_reg;
    logic [DWELL_W-1:0]    dwell_next;
    logic                  timeout_reg;
`else
    // The watchdog limit has no effect in this build.
    logic                  unused_max_dwell;
    assign unused_max_dwell = (MAX_DWELL > 0);
`endif

    // State register: holds the mode, the stage index and the dwell counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg  <= MODE_IDLE;
            idx_reg   <= '0;
`ifdef DWELL_TIMEOUT_EN
            dwell_reg <= '0;
`endif
        end else begin
            mode_reg  <= mode_next;
            idx_reg   <= idx_next;
`ifdef DWELL_TIMEOUT_EN
            dwell_reg <= dwell_next;
`endif
        end
    end

    // Next-state logic. The branch order below sets the priority between
    // the transitions.
    always_comb begin
        mode_next    = mode_reg;
        idx_next     = idx_reg;
        done_next    = 1'b0;
        timeout_next = 1'b0;
`ifdef DWELL_TIMEOUT_EN
        // The dwell counter clears unless we are holding in a stage.
        dwell_next   = '0;
`endif
        case (mode_reg)
            MODE_IDLE: begin
                idx_next = '0;
                if (en) begin
                    if (step) begin
                        mode_next = MODE_RUN;
                        idx_next  = '0;
                    end else begin
                        mode_next = MODE_ERR;
                    end
                end
            end
            MODE_RUN: begin
                if (idx_reg > LAST_IDX) begin
                    // A corrupted stage index returns to IDLE.
                    mode_next = MODE_IDLE;
                    idx_next  = '0;
                end else if (step) begin
                    if (en) begin
                        if (idx_reg == LAST_IDX) begin
                            mode_next = MODE_IDLE;
                            idx_next  = '0;
                            done_next = 1'b1;
                        end else begin
                            idx_next = idx_reg + IDX_W'(1);
                        end
                    end else begin
                        mode_next = MODE_ERR;
                        idx_next  = '0;
                    end
                end else begin
`ifdef DWELL_TIMEOUT_EN
                    // Holding in the stage. A step on the limit cycle is
                    // handled in the branch above, so it wins over the
                    // timeout.
                    if (dwell_reg >= DWELL_LIMIT) begin
                        mode_next    = MODE_ERR;
                        idx_next     = '0;
                        timeout_next = 1'b1;
                    end else begin
                        dwell_next = dwell_reg + DWELL_W'(1);
                    end
`endif
                end
            end
            MODE_ERR: begin
                idx_next = '0;
                if (!en) begin
                    mode_next = MODE_IDLE;
                end
            end
            default: begin
                mode_next = MODE_IDLE;
                idx_next  = '0;
            end
        endcase
    end

    // Output decode for the upcoming state. It is registered below so that
    // every output appears one cycle after its inputs were sampled.
    always_comb begin
        busy_next      = (mode_next == MODE_RUN);
        err_next       = (mode_next == MODE_ERR);
        stage_idx_next = (mode_next == MODE_RUN) ? idx_next : '0;
        err_cnt_next   = err_cnt_reg;
        // Count entries into ERROR only. Staying in ERROR does not count.
        if ((mode_next == MODE_ERR) && (mode_reg != MODE_ERR) && (err_cnt_reg != CNT_MAX)) begin
            err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
        end
    end

    // One-hot stage decode, one comparator per stage.
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_oh
        assign stage_oh_next[gi] = (mode_next == MODE_RUN) && (idx_next == IDX_W'(gi));
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_oh_reg  <= '0;
            stage_idx_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            stage_oh_reg  <= stage_oh_next;
            stage_idx_reg <= stage_idx_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            err_cnt_reg   <= err_cnt_next;
        end
    end

`ifdef DWELL_TIMEOUT_EN
    // Timeout pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= timeout_next;
        end
    end

    assign timeout = timeout_reg;
`else
    logic unused_timeout_next;
    assign unused_timeout_next = timeout_next;
    assign timeout = 1'b0;
`endif

    assign stage_oh  = stage_oh_reg;
    assign stage_idx = stage_idx_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_stage_seq_fsm.sv
// Directed bench for stage_seq_fsm with NUM_STAGES=4, ERR_CNT_W=2 and
// MAX_DWELL=4. Each step drives the inputs and queues the expected outputs.
// After the next clock edge the bench pops the queued entry and compares it.
module tb_stage_seq_fsm;

    logic       clk;
    logic       rst;
    logic       en;
    logic       step;
    logic [3:0] stage_oh;
    logic [3:0] stage_idx;
    logic       busy;
    logic       done;
    logic       err;
    logic       timeout;
    logic [1:0] err_cnt;

    int tests;
    int fails;

    typedef struct {
        logic [3:0] oh;
        logic [3:0] idx;
        logic       busy;
        logic       done;
        logic       err;
        logic       to;
        logic [1:0] cnt;
        string      tag;
    } exp_t;

    exp_t sb[$];

    stage_seq_fsm #(
        .NUM_STAGES(4),
        .IDX_W     (4),
        .ERR_CNT_W (2),
        .MAX_DWELL (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .step     (step),
        .stage_oh (stage_oh),
        .stage_idx(stage_idx),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .timeout  (timeout),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL time_limit: simulation still running at %0t", $time);
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    // Then sample 1 ns after the edge and check the entry at the queue head.
    task automatic cyc(input logic r, input logic e, input logic s,
                       input logic [3:0] oh, input logic [3:0] idx,
                       input logic b, input logic d, input logic er,
                       input logic to, input logic [1:0] cnt, input string tag);
        exp_t x;
        exp_t got;
        rst  = r;
        en   = e;
        step = s;
        x.oh = oh; x.idx = idx; x.busy = b; x.done = d;
        x.err = er; x.to = to; x.cnt = cnt; x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        tests++;
        assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL %s.queue: observed empty expected entry", tag);
        end
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk({got.tag, ".stage_oh"},  {4'd0, stage_oh},  {4'd0, got.oh});
            chk({got.tag, ".stage_idx"}, {4'd0, stage_idx}, {4'd0, got.idx});
            chk({got.tag, ".busy"},      {7'd0, busy},      {7'd0, got.busy});
            chk({got.tag, ".done"},      {7'd0, done},      {7'd0, got.done});
            chk({got.tag, ".err"},       {7'd0, err},       {7'd0, got.err});
            chk({got.tag, ".timeout"},   {7'd0, timeout},   {7'd0, got.to});
            chk({got.tag, ".err_cnt"},   {6'd0, err_cnt},   {6'd0, got.cnt});
            $display("[TB] %s rst=%0b en=%0b step=%0b -> oh=%b idx=%0d busy=%0b done=%0b err=%0b to=%0b cnt=%0d",
                     got.tag, r, e, s, stage_oh, stage_idx, busy, done, err, timeout, err_cnt);
        end
    endtask

    initial begin
        int hold_n;
        logic [1:0] c;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        en = 1'b0;
        step = 1'b0;

        // Reset state.
        cyc(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, "reset0");
        cyc(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, "reset1");

        // Full walk through all four stages, then done for a single cycle.
        cyc(0, 1, 1, 4'b0001, 0, 1, 0, 0, 0, 0, "seq_s0");
        cyc(0, 1, 1, 4'b0010, 1, 1, 0, 0, 0, 0, "seq_s1");
        cyc(0, 1, 1, 4'b0100, 2, 1, 0, 0, 0, 0, "seq_s2");
        cyc(0, 1, 1, 4'b1000, 3, 1, 0, 0, 0, 0, "seq_s3");
        cyc(0, 1, 1, 4'b0000, 0, 0, 1, 0, 0, 0, "seq_done");
        cyc(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, "seq_idle");

        // Hold in stage 0. The watchdog build holds only up to the dwell limit.
`ifdef DWELL_TIMEOUT_EN
        hold_n = 4;
`else
        hold_n = 10;
`endif
        cyc(0, 1, 1, 4'b0001, 0, 1, 0, 0, 0, 0, "hold_entry");
        for (int i = 0; i < hold_n; i++)
            cyc(0, 1, 0, 4'b0001, 0, 1, 0, 0, 0, 0, "hold_s0");
        cyc(0, 0, 1, 4'b0000, 0, 0, 0, 1, 0, 1, "step_no_en");
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 0, 4'b0000, 0, 0, 0, 1, 0, 1, "err_stay");
        cyc(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, "err_exit");

        // Errors raised from IDLE push the counter to saturation.
        cyc(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, "reset2");
        for (int i = 0; i < 4; i++) begin
            c = (i >= 2) ? 2'd3 : 2'(i + 1);
            cyc(0, 1, 0, 4'b0000, 0, 0, 0, 1, 0, c, "idle_err");
            cyc(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, c, "idle_back");
        end

        // Reset in the middle of stage 1 clears everything, including err_cnt.
        cyc(0, 1, 1, 4'b0001, 0, 1, 0, 0, 0, 3, "mid_s0");
        cyc(0, 1, 1, 4'b0010, 1, 1, 0, 0, 0, 3, "mid_s1");
        cyc(1, 1, 1, 4'b0000, 0, 0, 0, 0, 0, 0, "mid_rst0");
        cyc(1, 1, 1, 4'b0000, 0, 0, 0, 0, 0, 0, "mid_rst1");
        cyc(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, "post_rst");

        // Dwell watchdog in stage 1.
        cyc(0, 1, 1, 4'b0001, 0, 1, 0, 0, 0, 0, "wd_s0");
        cyc(0, 1, 1, 4'b0010, 1, 1, 0, 0, 0, 0, "wd_s1");
        for (int i = 0; i < 4; i++)
            cyc(0, 1, 0, 4'b0010, 1, 1, 0, 0, 0, 0, "wd_dwell");
`ifdef DWELL_TIMEOUT_EN
        cyc(0, 1, 0, 4'b0000, 0, 0, 0, 1, 1, 1, "wd_timeout");
        cyc(0, 1, 0, 4'b0000, 0, 0, 0, 1, 0, 1, "wd_pulse_end");
        cyc(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, "wd_idle");
        c = 2'd1;
`else
        cyc(0, 1, 0, 4'b0010, 1, 1, 0, 0, 0, 0, "wd_absent");
        cyc(0, 1, 0, 4'b0010, 1, 1, 0, 0, 0, 0, "wd_absent");
        cyc(0, 1, 1, 4'b0100, 2, 1, 0, 0, 0, 0, "wd_leave_s2");
        cyc(0, 1, 1, 4'b1000, 3, 1, 0, 0, 0, 0, "wd_leave_s3");
        cyc(0, 1, 1, 4'b0000, 0, 0, 1, 0, 0, 0, "wd_done");
        c = 2'd0;
`endif

        // A step on the dwell-limit cycle advances normally, with no timeout.
        cyc(0, 1, 1, 4'b0001, 0, 1, 0, 0, 0, c, "pri_s0");
        cyc(0, 1, 1, 4'b0010, 1, 1, 0, 0, 0, c, "pri_s1");
        for (int i = 0; i < 4; i++)
            cyc(0, 1, 0, 4'b0010, 1, 1, 0, 0, 0, c, "pri_dwell");
        cyc(0, 1, 1, 4'b0100, 2, 1, 0, 0, 0, c, "pri_limit_step");
        cyc(0, 1, 1, 4'b1000, 3, 1, 0, 0, 0, c, "pri_s3");

        // Step without en in the last stage goes to ERROR, not to done.
        cyc(0, 0, 1, 4'b0000, 0, 0, 0, 1, 0, c + 2'd1, "last_err");
        cyc(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, c + 2'd1, "last_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
